// File: rtl/i2c_pkg.sv
// Shared I2C master definitions: acknowledge bit levels and the read-sequencer
// state encodings (also used by i2c_master_write_seq).
package i2c_pkg;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam logic [2:0] RS_IDLE    = 3'd0;
    localparam logic [2:0] RS_RD_BIT  = 3'd1;
    localparam logic [2:0] RS_RD_GAP  = 3'd2;
    localparam logic [2:0] RS_ACK_BIT = 3'd3;
    localparam logic [2:0] RS_ACK_GAP = 3'd4;
    localparam logic [2:0] RS_FINISH  = 3'd5;

endpackage

// File: rtl/i2c_master_read_seq.sv
// Byte-level I2C read sequencer: drives the read_bit/write_bit engine handshakes to
// collect LEN bytes MSB first, answering each byte with ACK, or NACK after the last.
module i2c_master_read_seq
    import i2c_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  rd_go,
    input  logic                  rd_finish,
    input  logic                  rd_data,
    input  logic                  rd_error,
    output logic                  wr_go,
    output logic                  wr_data,
    input  logic                  wr_finish,
    input  logic                  wr_error,
    output logic [DATA_WIDTH-1:0] byte_data,
    output logic                  byte_valid,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);

    logic [2:0]            state_q,      state_d;
    logic [LEN_WIDTH-1:0]  remaining_q,  remaining_d;
    logic [CNT_W-1:0]      bit_cnt_q,    bit_cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q,      shreg_d;
    logic                  abort_q,      abort_d;
    logic                  busy_q,       busy_d;
    logic                  rd_go_q,      rd_go_d;
    logic                  wr_go_q,      wr_go_d;
    logic                  wr_data_q,    wr_data_d;
    logic [DATA_WIDTH-1:0] byte_data_q,  byte_data_d;
    logic                  byte_valid_q, byte_valid_d;
    logic                  done_q,       done_d;
    logic                  error_q,      error_d;

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        abort_d      = abort_q;
        busy_d       = busy_q;
        rd_go_d      = rd_go_q;
        wr_go_d      = wr_go_q;
        wr_data_d    = wr_data_q;
        byte_data_d  = byte_data_q;
        byte_valid_d = 1'b0;
        done_d       = 1'b0;
        error_d      = error_q;

        case (state_q)
            RS_IDLE: begin
                busy_d  = 1'b0;
                rd_go_d = 1'b0;
                wr_go_d = 1'b0;
                if (start) begin
                    busy_d    = 1'b1;
                    error_d   = 1'b0;
                    abort_d   = 1'b0;
                    bit_cnt_d = '0;
                    if (len != '0) begin
                        remaining_d = len;
                        rd_go_d     = 1'b1;
                        state_d     = RS_RD_BIT;
                    end else begin
                        remaining_d = '0;
                        state_d     = RS_FINISH;
                    end
                end
            end

            RS_RD_BIT: begin
                if (rd_finish) begin
                    rd_go_d = 1'b0;
                    if (rd_error) begin
                        abort_d = 1'b1;
                        state_d = RS_FINISH;
                    end else begin
                        shreg_d   = (shreg_q << 1) | DATA_WIDTH'(rd_data);
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        state_d   = RS_RD_GAP;
                    end
                end
            end

            // Single rd_go-low cycle so the bit engine can re-arm between bits.
            RS_RD_GAP: begin
                if (bit_cnt_q < CNT_FULL) begin
                    rd_go_d = 1'b1;
                    state_d = RS_RD_BIT;
                end else begin
                    byte_data_d  = shreg_q;
                    byte_valid_d = 1'b1;
                    wr_data_d    = (remaining_q == LEN_WIDTH'(1)) ? I2C_NACK : I2C_ACK;
                    wr_go_d      = 1'b1;
                    state_d      = RS_ACK_BIT;
                end
            end

            RS_ACK_BIT: begin
                if (wr_finish) begin
                    wr_go_d = 1'b0;
                    if (wr_error) begin
                        abort_d = 1'b1;
                        state_d = RS_FINISH;
                    end else begin
                        if (remaining_q != '0) begin
                            remaining_d = remaining_q - LEN_WIDTH'(1);
                        end
                        bit_cnt_d = '0;
                        state_d   = RS_ACK_GAP;
                    end
                end
            end

            RS_ACK_GAP: begin
                if (remaining_q == '0) begin
                    state_d = RS_FINISH;
                end else begin
                    rd_go_d = 1'b1;
                    state_d = RS_RD_BIT;
                end
            end

            // error is raised together with done, from the abort flag noted earlier.
            RS_FINISH: begin
                done_d  = 1'b1;
                error_d = abort_q;
                rd_go_d = 1'b0;
                wr_go_d = 1'b0;
                state_d = RS_IDLE;
            end

            default: begin
                rd_go_d = 1'b0;
                wr_go_d = 1'b0;
                state_d = RS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RS_IDLE;
            remaining_q  <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            abort_q      <= 1'b0;
            busy_q       <= 1'b0;
            rd_go_q      <= 1'b0;
            wr_go_q      <= 1'b0;
            wr_data_q    <= 1'b0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            abort_q      <= abort_d;
            busy_q       <= busy_d;
            rd_go_q      <= rd_go_d;
            wr_go_q      <= wr_go_d;
            wr_data_q    <= wr_data_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign busy       = busy_q;
    assign rd_go      = rd_go_q;
    assign wr_go      = wr_go_q;
    assign wr_data    = wr_data_q;
    assign byte_data  = byte_data_q;
    assign byte_valid = byte_valid_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_i2c_master_read_seq.sv
// Bench for i2c_master_read_seq with behavioural read_bit/write_bit engine models.
module tb_i2c_master_read_seq;

    localparam int DW     = 8;
    localparam int LW     = 8;
    localparam int RD_LAT = 3;
    localparam int WR_LAT = 2;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic          busy, rd_go, wr_go, wr_data, byte_valid, done, error;
    logic [DW-1:0] byte_data;
    logic          rd_finish = 1'b0, rd_data = 1'b0, rd_error = 1'b0;
    logic          wr_finish = 1'b0, wr_error = 1'b0;

    always #5 clock = ~clock;

    i2c_master_read_seq #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .len(len), .busy(busy),
        .rd_go(rd_go), .rd_finish(rd_finish), .rd_data(rd_data), .rd_error(rd_error),
        .wr_go(wr_go), .wr_data(wr_data), .wr_finish(wr_finish), .wr_error(wr_error),
        .byte_data(byte_data), .byte_valid(byte_valid), .done(done), .error(error)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // engine model controls and monitor state
    bit         rd_q[$];
    int         rd_err_at = -1, rd_bit_idx = 0;
    int         wr_err_at = -1, wr_idx = 0;
    bit         spur_req = 1'b0;
    int         spur_fired = 0;
    int         wr_unstable = 0;
    int         rd_rise = 0, wr_rise = 0, gap1 = 0, done_cnt = 0, bv_nowr = 0;
    logic       done_err = 1'b0;
    logic [8:0] bv_q[$];

    initial begin : rd_model
        int  cnt;
        bit  act;
        act = 0;
        cnt = 0;
        forever begin
            @(negedge clock);
            rd_finish = 1'b0;
            rd_error  = 1'b0;
            if (!reset_n) begin
                act = 0;
            end else if (act) begin
                cnt--;
                if (cnt == 0) begin
                    act       = 0;
                    rd_finish = 1'b1;
                    rd_data   = (rd_q.size() > 0) ? rd_q.pop_front() : 1'b0;
                    rd_error  = (rd_bit_idx == rd_err_at);
                    rd_bit_idx++;
                end
            end else if (rd_go) begin
                act = 1;
                cnt = RD_LAT;
            end else if (spur_req) begin
                spur_req  = 1'b0;
                spur_fired++;
                rd_finish = 1'b1;
                rd_data   = 1'b1;
            end
        end
    end

    initial begin : wr_model
        int   cnt;
        bit   act;
        logic wd0;
        act = 0;
        cnt = 0;
        wd0 = 1'b0;
        forever begin
            @(negedge clock);
            wr_finish = 1'b0;
            wr_error  = 1'b0;
            if (!reset_n) begin
                act = 0;
            end else if (act) begin
                cnt--;
                if (cnt == 0) begin
                    act       = 0;
                    wr_finish = 1'b1;
                    wr_error  = (wr_idx == wr_err_at);
                    if (wr_data !== wd0) wr_unstable++;
                    wr_idx++;
                end
            end else if (wr_go) begin
                act = 1;
                cnt = WR_LAT;
                wd0 = wr_data;
            end
        end
    end

    initial begin : monitor
        logic prev_rd, prev_wr;
        int   low_run;
        prev_rd = 1'b0;
        prev_wr = 1'b0;
        low_run = 0;
        forever begin
            @(negedge clock);
            if (rd_go && !prev_rd) begin
                rd_rise++;
                if (low_run == 1) gap1++;
            end
            if (!rd_go) low_run++;
            else low_run = 0;
            if (wr_go && !prev_wr) wr_rise++;
            if (byte_valid) begin
                bv_q.push_back({wr_data, byte_data});
                if (!wr_go) bv_nowr++;
            end
            if (done) begin
                done_cnt++;
                done_err = error;
            end
            prev_rd = rd_go;
            prev_wr = wr_go;
        end
    end

    task automatic clr_mon();
        rd_rise = 0; wr_rise = 0; gap1 = 0; done_cnt = 0; bv_nowr = 0;
        wr_unstable = 0; spur_fired = 0; bv_q.delete();
    endtask

    task automatic load(input int l, input logic [31:0] bytes, input int eb, input int we);
        logic [7:0] b;
        rd_q.delete();
        for (int i = 0; i < l && i < 4; i++) begin
            b = 8'((bytes >> (24 - 8 * i)) & 32'hFF);
            for (int k = DW - 1; k >= 0; k--) rd_q.push_back(b[k]);
        end
        rd_err_at = eb; rd_bit_idx = 0;
        wr_err_at = we; wr_idx = 0;
        clr_mon();
    endtask

    task automatic kick(input int l);
        @(negedge clock);
        start = 1'b1;
        len   = LW'(l);
        @(posedge clock);
        #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("error_cleared_on_start", error, 0);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (done_cnt == 0 && t < 3000) begin
            @(negedge clock);
            t++;
        end
        check("done_within_budget", done_cnt != 0, 1);
        repeat (3) @(negedge clock);
    endtask

    typedef struct {
        int          len;
        logic [31:0] bytes;
        int          eb;
        int          we;
        int          nb;
        logic        err;
        int          nrd;
        int          nwr;
        int          ng1;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] exp_b;

    initial begin
        vecs[0] = '{len:1, bytes:32'hA5000000, eb:-1, we:-1, nb:1, err:1'b0, nrd:8,  nwr:1, ng1:7};
        vecs[1] = '{len:3, bytes:32'h13579B00, eb:-1, we:-1, nb:3, err:1'b0, nrd:24, nwr:3, ng1:21};
        vecs[2] = '{len:4, bytes:32'h11223344, eb:13, we:-1, nb:1, err:1'b1, nrd:14, nwr:1, ng1:12};
        vecs[3] = '{len:2, bytes:32'hF00F0000, eb:-1, we:-1, nb:2, err:1'b0, nrd:16, nwr:2, ng1:14};
        vecs[4] = '{len:2, bytes:32'hC33C0000, eb:-1, we:0,  nb:1, err:1'b1, nrd:8,  nwr:1, ng1:7};
        vecs[5] = '{len:0, bytes:32'h00000000, eb:-1, we:-1, nb:0, err:1'b0, nrd:0,  nwr:0, ng1:0};

        repeat (3) @(negedge clock);
        check("reset_outputs", {busy, rd_go, wr_go, wr_data, byte_valid, done, error, byte_data}, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        for (int v = 0; v < 6; v++) begin
            load(vecs[v].len, vecs[v].bytes, vecs[v].eb, vecs[v].we);
            kick(vecs[v].len);
            wait_done();
            check("done_count", done_cnt, 1);
            check("error_at_done", done_err, vecs[v].err);
            check("error_sticky", error, vecs[v].err);
            check("busy_idle", busy, 0);
            check("rd_go_rises", rd_rise, vecs[v].nrd);
            check("wr_go_rises", wr_rise, vecs[v].nwr);
            check("rd_gap_one_cycle", gap1, vecs[v].ng1);
            check("byte_valid_count", bv_q.size(), vecs[v].nb);
            check("byte_valid_with_wr_go", bv_nowr, 0);
            check("wr_data_stable", wr_unstable, 0);
            for (int i = 0; i < vecs[v].nb && i < bv_q.size(); i++) begin
                exp_b = 8'((vecs[v].bytes >> (24 - 8 * i)) & 32'hFF);
                check("byte_data", bv_q[i][7:0], exp_b);
                check("ack_bit", bv_q[i][8], (i == vecs[v].len - 1) ? 1 : 0);
            end
        end

        // len=0 cycle timing: done two edges after start, then busy drops with done
        load(0, 32'h0, -1, -1);
        @(negedge clock);
        start = 1'b1;
        len   = '0;
        @(posedge clock);
        #1;
        start = 1'b0;
        check("len0_e1_done", done, 0);
        check("len0_e1_busy", busy, 1);
        @(posedge clock);
        #1;
        check("len0_e2_done", done, 1);
        check("len0_e2_error", error, 0);
        @(posedge clock);
        #1;
        check("len0_e3_done", done, 0);
        check("len0_e3_busy", busy, 0);
        repeat (2) @(negedge clock);
        check("len0_no_go", rd_rise + wr_rise, 0);

        // asynchronous reset while waiting for the ACK bit
        load(2, 32'h817E0000, -1, -1);
        kick(2);
        begin
            int t;
            t = 0;
            while (!wr_go && t < 500) begin
                @(negedge clock);
                t++;
            end
        end
        check("reached_ack_bit", {busy, wr_go, byte_data}, {1'b1, 1'b1, 8'h81});
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", {busy, rd_go, wr_go, wr_data, byte_valid, done, error, byte_data}, 0);
        repeat (3) @(negedge clock);
        check("no_done_on_reset", done_cnt, 0);
        reset_n = 1'b1;
        @(negedge clock);
        load(1, 32'h5A000000, -1, -1);
        kick(1);
        wait_done();
        check("post_reset_bytes", bv_q.size(), 1);
        if (bv_q.size() > 0) check("post_reset_byte", bv_q[0], {1'b1, 8'h5A});
        check("post_reset_error", error, 0);

        // start while busy and a stray rd_finish with rd_go low are ignored
        load(2, 32'h3CC30000, -1, -1);
        kick(2);
        repeat (5) @(negedge clock);
        start = 1'b1;
        len   = LW'(7);
        @(negedge clock);
        start = 1'b0;
        spur_req = 1'b1;
        wait_done();
        repeat (30) @(negedge clock);
        check("spurious_fired", spur_fired, 1);
        check("busy_start_done_count", done_cnt, 1);
        check("busy_start_rd_rises", rd_rise, 16);
        check("busy_start_wr_rises", wr_rise, 2);
        check("busy_start_bytes", bv_q.size(), 2);
        if (bv_q.size() > 1) begin
            check("busy_start_byte0", bv_q[0], {1'b0, 8'h3C});
            check("busy_start_byte1", bv_q[1], {1'b1, 8'hC3});
        end
        check("busy_start_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
